// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the UART command front end.
//            Holds the state encodings for the command assembler and the
//            transmit serialiser, the frame length, the default baud
//            divider and the positive-acknowledge response byte.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XMIT = 1'b1
    } tx_state_t;

    localparam int         UART_FRAME_BITS = 10;
    localparam int         DFLT_BAUD_DIV   = 2604;
    localparam logic [7:0] POS_ACK         = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 serialiser for the one-byte response. A request seen in
//            IDLE is accepted, the byte is framed as {stop, data, start},
//            and the frame is shifted out LSB first at BAUD_DIV clocks per
//            bit. o_done rises when the stop bit has been fully sent and
//            stays high until the next accepted request.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            i_send  - single-cycle transmit request (ignored while busy)
//            i_data  - byte to send, sampled when i_send is accepted
//            o_tx    - serial output, idles high
//            o_done  - previous frame fully transmitted
// Revision : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DFLT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_send,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(UART_FRAME_BITS + 1);

    tx_state_t         r_state;
    tx_state_t         w_next_state;
    logic [9:0]        r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic              r_tx;
    logic              r_done;

    logic              w_baud_end;
    logic              w_all_bits;
    logic              w_load;
    logic              w_shift;
    logic              w_finish;

    assign w_baud_end = (r_baud == BAUD_W'(BAUD_DIV - 1));
    assign w_all_bits = (r_bit == BIT_W'(UART_FRAME_BITS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_send)     w_next_state = XMIT;
            XMIT:    if (w_all_bits) w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    // Control outputs. The bit counter reaches 10 one bit-period after the
    // stop bit was loaded onto the line; o_tx is one register behind the
    // shifter, so that extra cycle lines the finish up with the end of the
    // stop bit as seen on the pin.
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: w_load = i_send;
            XMIT: begin
                w_shift  = !w_all_bits && w_baud_end;
                w_finish = w_all_bits;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_tx <= (r_state == XMIT) ? r_shift[0] : 1'b1;
            if (w_load) begin
                r_shift <= {1'b1, i_data, 1'b0};
                r_baud  <= '0;
                r_bit   <= '0;
                r_done  <= 1'b0;
            end else if (r_state == XMIT) begin
                if (w_shift) begin
                    r_shift <= {1'b1, r_shift[9:1]};
                    r_baud  <= '0;
                    r_bit   <= r_bit + BIT_W'(1);
                end else begin
                    r_baud  <= r_baud + BAUD_W'(1);
                end
                if (w_finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_wrapper
// Purpose  : Receive-side command front end. Deserialises 8N1 bytes from
//            RX, pairs them high byte first into a 16-bit command with a
//            ready/clear handshake, and sends a one-byte response on TX.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            RX           - serial input (asynchronous, idles high)
//            TX           - serial output (idles high)
//            cmd          - last complete command {high, low}
//            cmd_rdy      - cmd holds a complete command
//            clr_cmd_rdy  - consumer acknowledge, clears cmd_rdy
//            send_resp    - single-cycle request to transmit resp
//            resp         - response byte
//            resp_sent    - previous response fully transmitted
// Options  : UART_CMD_TIMEOUT_EN - when defined, a high byte left waiting
//            for TIMEOUT_CLKS clocks without its low byte is discarded.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV     = DFLT_BAUD_DIV,
    parameter int TIMEOUT_CLKS = 104160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent
);

    localparam int RX_BW = $clog2(BAUD_DIV + 1);

    // Elaboration-time parameter sanity checks
    if (BAUD_DIV < 16) begin : g_chk_baud
        $error("uart_cmd_wrapper: BAUD_DIV must be at least 16");
    end
    if (TIMEOUT_CLKS < 1) begin : g_chk_timeout
        $error("uart_cmd_wrapper: TIMEOUT_CLKS must be positive");
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic             r_rx_busy;
    logic [RX_BW-1:0] r_rx_baud;
    logic [3:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;

    logic             w_rx_fall;
    logic             w_rx_tick;
    logic             w_rx_last;
    logic             w_rx_data;
    logic             w_byte_rdy;
    logic             w_frame_err;

    assign w_rx_fall   = !r_rx_busy && r_rx_prev && !r_rx_sync;
    assign w_rx_tick   = r_rx_busy && (r_rx_baud == RX_BW'(1));
    assign w_rx_last   = (r_rx_bit == 4'(UART_FRAME_BITS - 1));
    assign w_rx_data   = (r_rx_bit >= 4'd1) && (r_rx_bit <= 4'd8);
    // Judged on the stop sample itself so the assembler loads on that edge.
    assign w_byte_rdy  = w_rx_tick && w_rx_last && r_rx_sync;
    assign w_frame_err = w_rx_tick && w_rx_last && !r_rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (w_rx_fall) begin
                // Half a bit first so every later sample lands mid-bit.
                r_rx_busy <= 1'b1;
                r_rx_baud <= RX_BW'(BAUD_DIV / 2);
                r_rx_bit  <= '0;
            end else if (r_rx_busy) begin
                if (w_rx_tick) begin
                    r_rx_baud <= RX_BW'(BAUD_DIV);
                    r_rx_bit  <= r_rx_bit + 4'd1;
                    if (w_rx_data) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    end
                    if (w_rx_last) begin
                        r_rx_busy <= 1'b0;
                    end
                end else begin
                    r_rx_baud <= r_rx_baud - RX_BW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command assembler
    // ------------------------------------------------------------------
    asm_state_t  r_asm_state;
    asm_state_t  w_asm_next;
    logic [7:0]  r_hi;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        w_load_hi;
    logic        w_load_cmd;
    logic        w_timeout;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_asm_state == WAIT_LO) &&
                       (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_load_hi) begin
            r_to_cnt <= '0;
        end else if ((r_asm_state == WAIT_LO) && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm_state <= WAIT_HI;
        end else begin
            r_asm_state <= w_asm_next;
        end
    end

    // Next-state logic; a completed low byte takes priority over timeout.
    always_comb begin
        w_asm_next = r_asm_state;
        case (r_asm_state)
            WAIT_HI: if (w_byte_rdy) w_asm_next = WAIT_LO;
            WAIT_LO: if (w_byte_rdy || w_frame_err || w_timeout)
                         w_asm_next = WAIT_HI;
            default: w_asm_next = WAIT_HI;
        endcase
    end

    // Output decode
    always_comb begin
        w_load_hi  = 1'b0;
        w_load_cmd = 1'b0;
        case (r_asm_state)
            WAIT_HI: w_load_hi  = w_byte_rdy;
            WAIT_LO: w_load_cmd = w_byte_rdy;
            default: ;
        endcase
    end

    // Command registers. A new high byte withdraws cmd_rdy; completion
    // beats a simultaneous consumer clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if (w_load_hi) begin
                r_hi <= r_rx_shift;
            end
            if (w_load_cmd) begin
                r_cmd     <= {r_hi, r_rx_shift};
                r_cmd_rdy <= 1'b1;
            end else if (w_load_hi || clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_send (send_resp),
        .i_data (resp),
        .o_tx   (TX),
        .o_done (resp_sent)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_wrapper
// Purpose  : Self-checking bench for uart_cmd_wrapper. Command pairs come
//            from a vector table; a scoreboard holds expected commands and
//            response frames, popped when the DUT raises cmd_rdy or a frame
//            completes on TX. Hand sequences cover reset mid-frame, response
//            timing, clear/set collision, full duplex and timeout.
// Options  : UART_CMD_TIMEOUT_EN selects the matching timeout expectation.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_wrapper;
    import uart_cmd_pkg::*;

    localparam int B       = 16;
    localparam int TO      = 600;
    localparam int LAT_MAX = 2 + B / 2 + 9 * B + 1;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    uart_cmd_wrapper #(
        .BAUD_DIV     (B),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int t_fall  = 0;

    logic [15:0] cmd_q[$];
    logic [7:0]  tx_q[$];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        lo_stop;
        logic        do_clr;
        logic        exp_rdy;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        t_fall = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    // Command scoreboard: compare on every rising cmd_rdy.
    initial begin
        logic prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_rdy && !prev_rdy) begin
                if (cmd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got cmd %h, expected none", cmd);
                end else begin
                    check("cmd_value", cmd, cmd_q.pop_front());
                end
                check("cmd_latency_ok", (cyc - t_fall) <= LAT_MAX, 1);
            end
            prev_rdy = cmd_rdy;
        end
    end

    // Response scoreboard: capture each TX frame at mid-bit.
    initial begin
        logic       prev_tx;
        logic       ok;
        logic [9:0] bits;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev_tx && !TX) begin
                ok = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    repeat ((i == 0) ? B / 2 : B) @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                    bits[i] = TX;
                end
                if (ok) begin
                    if (tx_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got frame %b, expected none", bits);
                    end else begin
                        check("tx_frame", bits, {1'b1, tx_q.pop_front(), 1'b0});
                    end
                end
            end
            prev_tx = TX;
        end
    end

    initial begin
        int lat;

        vecs[0] = '{8'h60, 8'h01, 1'b1, 1'b1, 1'b1, 16'h6001};
        vecs[1] = '{8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 16'h1234};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 16'hFF00};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h00FF};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 16'hA55A};
        vecs[5] = '{8'h60, 8'h00, 1'b0, 1'b0, 1'b0, 16'hA55A};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0000};

        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_resp_sent", resp_sent, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-frame: a half-assembled command and a response in flight.
        send_byte(8'h77, 1'b1);
        fork
            send_byte(8'h00, 1'b1);
            begin
                repeat (3) @(negedge clk);
                resp      = 8'h5A;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                repeat (4 * B) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("midrst_tx", TX, 1);
                check("midrst_cmd", cmd, 16'h0000);
                check("midrst_cmd_rdy", cmd_rdy, 0);
                check("midrst_resp_sent", resp_sent, 0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("postrst_tx", TX, 1);

        // Table-driven command pairs
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_rdy) cmd_q.push_back(vecs[i].exp_cmd);
            send_byte(vecs[i].hi, 1'b1);
            send_byte(vecs[i].lo, vecs[i].lo_stop);
            check($sformatf("vec%0d_rdy", i), cmd_rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_cmd", i), cmd, vecs[i].exp_cmd);
            if (vecs[i].do_clr) begin
                @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check($sformatf("vec%0d_clr_rdy", i), cmd_rdy, 0);
                check($sformatf("vec%0d_clr_cmd", i), cmd, vecs[i].exp_cmd);
            end
        end

        // Response transmit timing
        @(negedge clk);
        resp      = POS_ACK;
        send_resp = 1'b1;
        tx_q.push_back(POS_ACK);
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_high_at_accept", TX, 1);
        check("resp_sent_low", resp_sent, 0);
        lat = 0;
        for (int i = 1; i <= 10 * B + 20; i++) begin
            @(negedge clk);
            if (i == 1) check("tx_start_edge", TX, 0);
            if (resp_sent) begin
                lat = i;
                break;
            end
        end
        check("resp_sent_latency", lat, 10 * B + 1);
        repeat (2 * B) @(negedge clk);
        check("resp_sent_held", resp_sent, 1);

        // Completion and clear in the same cycle: the set must win.
        cmd_q.push_back(16'hC33C);
        send_byte(8'hC3, 1'b1);
        clr_cmd_rdy = 1'b1;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                for (int i = 0; i < 14 * B; i++) begin
                    @(negedge clk);
                    if (cmd_rdy) break;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        @(negedge clk);
        check("set_wins_rdy", cmd_rdy, 1);
        check("set_wins_cmd", cmd, 16'hC33C);

        // Full duplex, with a second request during XMIT ignored
        cmd_q.push_back(16'h0000);
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'h00, 1'b1);
            end
            begin
                repeat (3 * B) @(negedge clk);
                resp      = POS_ACK;
                send_resp = 1'b1;
                tx_q.push_back(POS_ACK);
                @(negedge clk);
                send_resp = 1'b0;
                check("fd_resp_sent_cleared", resp_sent, 0);
                repeat (2 * B) @(negedge clk);
                resp      = 8'h3C;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                for (int i = 0; i < 10 * B + 20; i++) begin
                    @(negedge clk);
                    if (resp_sent) break;
                end
                check("fd_resp_sent", resp_sent, 1);
            end
        join
        check("fd_cmd_rdy", cmd_rdy, 1);
        check("fd_cmd", cmd, 16'h0000);
        repeat (12 * B) @(negedge clk);

        // Inter-byte timeout
        send_byte(8'h40, 1'b1);
        repeat (TO + B) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        cmd_q.push_back(16'h6000);
        send_byte(8'h60, 1'b1);
        send_byte(8'h00, 1'b1);
        check("to_cmd_rdy", cmd_rdy, 1);
        check("to_cmd", cmd, 16'h6000);
`else
        cmd_q.push_back(16'h4060);
        send_byte(8'h60, 1'b1);
        check("to_cmd_rdy", cmd_rdy, 1);
        check("to_cmd", cmd, 16'h4060);
        send_byte(8'h00, 1'b1);
        check("to_next_hi_rdy", cmd_rdy, 0);
        check("to_cmd_held", cmd, 16'h4060);
`endif

        repeat (4 * B) @(negedge clk);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
